// File: rtl/register_op_sequencer_pkg.sv
// Shared encodings and widths for the register op sequencer.
package register_op_sequencer_pkg;

  localparam int unsigned COUNT_W = 3;
  localparam int unsigned DATA_W  = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_INV  = 2'b01,
    OP_SHR  = 2'b10,
    OP_SHL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/register_op_sequencer_if.sv
// Command / result handshake bundle between a requester and the sequencer.
interface register_op_sequencer_if;
  import register_op_sequencer_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [COUNT_W-1:0] cmd_count;
  logic [DATA_W-1:0]  cmd_data;
  logic               res_valid;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data;

  // Requester side: issues commands and consumes results.
  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/register_op_sequencer_mode_datapath.sv
// 4-bit working register with a load port and the per-step op mux.
module mode_datapath
  import register_op_sequencer_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_step,
  input  op_e               i_op,
  output logic [DATA_W-1:0] o_reg
);

  logic [DATA_W-1:0] r_reg;
  logic [DATA_W-1:0] w_next;

  // One application of the selected op to the current register value.
  always_comb begin
    w_next = r_reg;
    case (i_op)
      OP_HOLD: w_next = r_reg;
      OP_INV:  w_next = ~r_reg;
      OP_SHR:  w_next = {1'b0, r_reg[DATA_W-1:1]};
      OP_SHL:  w_next = {r_reg[DATA_W-2:0], 1'b0};
      default: w_next = r_reg;
    endcase
  end

  // Load takes priority over stepping; otherwise the value is held.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       r_reg <= '0;
    else if (i_load) r_reg <= i_load_data;
    else if (i_step) r_reg <= w_next;
  end

  assign o_reg = r_reg;

endmodule

// File: rtl/register_op_sequencer.sv
// Accepts a (op, count, data) command, applies op count times, returns the result.
module register_op_sequencer
  import register_op_sequencer_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  register_op_sequencer_if.slave bus,
  output logic                  busy
);

  state_e             r_state;
  state_e             w_next_state;
  logic [COUNT_W-1:0] r_remaining;
  op_e                r_op;
  logic               w_accept;
  logic               w_step;
  logic [DATA_W-1:0]  w_reg;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and per-cycle control; accept depends only on state and cmd_valid.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = (bus.cmd_count == '0) ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_step = 1'b1;
        if (r_remaining == COUNT_W'(1)) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Op latch and remaining-application counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_remaining <= '0;
      r_op        <= OP_HOLD;
    end else if (w_accept) begin
      r_remaining <= bus.cmd_count;
      r_op        <= op_e'(bus.cmd_op);
    end else if (w_step) begin
      r_remaining <= r_remaining - COUNT_W'(1);
    end
  end

  mode_datapath u_datapath (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_load      (w_accept),
    .i_load_data (bus.cmd_data),
    .i_step      (w_step),
    .i_op        (r_op),
    .o_reg       (w_reg)
  );

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.res_valid = (r_state == ST_DONE);
  assign bus.res_data  = w_reg;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_register_op_sequencer.sv
module tb_register_op_sequencer;

  logic CLK;
  logic RESET;
  logic busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  register_op_sequencer_if bus_if ();

  register_op_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_if.slave),
    .busy  (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference: apply the op cnt times with plain arithmetic on a 0..15 value.
  function automatic logic [3:0] ref_result(input logic [1:0] op, input int unsigned cnt,
                                            input logic [3:0] d);
    int unsigned v;
    v = d;
    for (int unsigned i = 0; i < cnt; i++) begin
      case (op)
        2'd1:    v = 15 - v;
        2'd2:    v = v / 2;
        2'd3:    v = (v * 2) % 16;
        default: v = v;
      endcase
    end
    return v[3:0];
  endfunction

  task automatic junk_cmd();
    bus_if.cmd_op    = 2'($urandom_range(0, 3));
    bus_if.cmd_count = 3'($urandom_range(0, 7));
    bus_if.cmd_data  = 4'($urandom_range(0, 15));
  endtask

  // Issue one command from IDLE (called at a negedge), wait for the result,
  // stall the consumer, then consume. Returns at a negedge in IDLE.
  task automatic run_cmd(input logic [1:0] op, input int unsigned cnt, input logic [3:0] data,
                         input int unsigned stall);
    int unsigned lat;
    logic [3:0]  exp;
    logic [3:0]  held;
    exp = ref_result(op, cnt, data);
    check("cmd_ready_idle", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_count = 3'(cnt);
    bus_if.cmd_data  = data;
    @(negedge CLK);
    bus_if.cmd_valid = 1'b0;
    junk_cmd();
    lat = 1;
    while (!bus_if.res_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("latency", lat, cnt + 1);
    check("res_data", 32'(bus_if.res_data), 32'(exp));
    check("busy_done", 32'(busy), 32'd1);
    check("cmd_ready_done", 32'(bus_if.cmd_ready), 32'd0);
    held = bus_if.res_data;
    for (int unsigned s = 0; s < stall; s++) begin
      bus_if.cmd_valid = 1'b1;
      junk_cmd();
      @(negedge CLK);
      check("stall_valid", 32'(bus_if.res_valid), 32'd1);
      check("stall_data", 32'(bus_if.res_data), 32'(held));
      check("stall_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    end
    // cmd_valid stays high across the consume edge; it must not be taken there.
    bus_if.cmd_valid = 1'b1;
    bus_if.res_ready = 1'b1;
    @(negedge CLK);
    bus_if.res_ready = 1'b0;
    bus_if.cmd_valid = 1'b0;
    check("consumed_valid", 32'(bus_if.res_valid), 32'd0);
    check("consumed_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0]  q[$];
    int unsigned cyc, last_acc, last_cnt, n_acc, n_res;
    logic [3:0]  exp_q;
    bit          pend;

    RESET            = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.res_ready = 1'b0;
    bus_if.cmd_op    = 2'd0;
    bus_if.cmd_count = 3'd0;
    bus_if.cmd_data  = 4'd0;
    repeat (2) @(negedge CLK);
    check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_data", 32'(bus_if.res_data), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Directed cases.
    run_cmd(2'd1, 1, 4'b1011, 0);
    run_cmd(2'd2, 2, 4'b1011, 0);
    run_cmd(2'd3, 3, 4'b1011, 0);
    run_cmd(2'd0, 0, 4'b0110, 0);
    run_cmd(2'd0, 7, 4'b0110, 0);
    run_cmd(2'd1, 4, 4'b1001, 0);
    run_cmd(2'd2, 4, 4'b1111, 0);
    run_cmd(2'd3, 5, 4'b1111, 0);
    run_cmd(2'd1, 2, 4'b0101, 5);

    // Randomized commands with random consumer stalls.
    for (int i = 0; i < 30; i++)
      run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 7),
              4'($urandom_range(0, 15)), $urandom_range(0, 3));

    // Reset in the middle of a shift-left count-5 command.
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 2'd3;
    bus_if.cmd_count = 3'd5;
    bus_if.cmd_data  = 4'b0011;
    @(negedge CLK);
    bus_if.cmd_valid = 1'b0;
    @(negedge CLK);
    check("exec_busy", 32'(busy), 32'd1);
    RESET = 1'b1;
    #1;
    check("midrst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("midrst_res_valid", 32'(bus_if.res_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_res_data", 32'(bus_if.res_data), 32'd0);
    @(negedge CLK);
    check("midrst_hold_valid", 32'(bus_if.res_valid), 32'd0);
    RESET = 1'b0;
    run_cmd(2'd1, 2, 4'b1111, 0);

    // Back-to-back: cmd_valid held high, res_ready tied high.
    cyc = 0; last_acc = 0; last_cnt = 0; n_acc = 0; n_res = 0; pend = 1'b0;
    bus_if.res_ready = 1'b1;
    bus_if.cmd_valid = 1'b1;
    junk_cmd();
    while (cyc < 500 && n_res < 12) begin
      if (bus_if.res_valid) begin
        if (q.size() == 0) begin
          check("b2b_unexpected", 32'd1, 32'd0);
        end else begin
          exp_q = q.pop_front();
          check("b2b_data", 32'(bus_if.res_data), 32'(exp_q));
        end
        n_res++;
      end
      if (bus_if.cmd_ready && n_acc < 12) begin
        if (n_acc > 0) check("b2b_interval", cyc - last_acc, last_cnt + 2);
        q.push_back(ref_result(bus_if.cmd_op, bus_if.cmd_count, bus_if.cmd_data));
        last_acc = cyc;
        last_cnt = bus_if.cmd_count;
        n_acc++;
        pend = 1'b1;
      end
      @(negedge CLK);
      cyc++;
      if (pend) begin
        pend = 1'b0;
        if (n_acc >= 12) bus_if.cmd_valid = 1'b0;
        else             junk_cmd();
      end
    end
    check("b2b_results", n_res, 32'd12);
    bus_if.res_ready = 1'b0;
    bus_if.cmd_valid = 1'b0;
    @(negedge CLK);
    check("b2b_end_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_op_sequencer.md
REGISTER_OP_SEQUENCER -- requirements
Module: register_op_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, rising-edge clock.
REQ-002 SHALL have port RESET, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port cmd_valid, input, 1, command present.
REQ-004 SHALL have port cmd_ready, output, 1, command accepted this cycle when high with cmd_valid.
REQ-005 SHALL have port cmd_op, input, 2: 00 hold, 01 invert, 10 shift right, 11 shift left.
REQ-006 SHALL have port cmd_count, input, 3, number of op applications (0..7).
REQ-007 SHALL have port cmd_data, input, 4, initial register value.
REQ-008 SHALL have port res_valid, output, 1, result available.
REQ-009 SHALL have port res_ready, input, 1, consumer takes result.
REQ-010 SHALL have port res_data, output, 4, final register value.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-013 SHALL drive cmd_ready high only in IDLE, as a registered-state decode with no combinational path from cmd_valid.
REQ-014 SHALL, on accept edge k (cmd_valid and cmd_ready), load reg with cmd_data, load remaining with cmd_count, latch op, then go to DONE if cmd_count = 0, else to EXEC.
REQ-015 SHALL, on each EXEC edge, set reg to f(op, reg) and decrement remaining, moving to DONE on the edge where remaining goes 1 to 0.
REQ-016 SHALL define f: hold gives reg; invert gives bitwise NOT reg; shift right gives {0, reg[3:1]}; shift left gives {reg[2:0], 0}.
REQ-017 SHALL make res_valid rise after edge k+cmd_count, giving latency cmd_count+1 cycles from the accept cycle.
REQ-018 SHALL drive res_valid high only in DONE, with res_data = reg held stable while res_valid is high.
REQ-019 SHALL, in DONE, go to IDLE on the edge where res_ready is high, and otherwise hold DONE indefinitely.
REQ-020 SHALL ignore cmd_* inputs outside IDLE, so no command is accepted in the same cycle a result is consumed.
REQ-021 SHALL ignore a cmd_valid pulse dropped before acceptance, with no state change.
REQ-022 SHALL yield 0 for shifts with count >= 4, and the original data for an even number of inverts.
REQ-023 SHALL keep res_data at the last result outside DONE (don't-care to consumers).

Reset
REQ-024 SHALL, with RESET high, force state to IDLE, reg to 0, remaining to 0, op to 00, res_valid to 0, busy to 0 and cmd_ready to 1.
REQ-025 SHALL, when RESET asserts mid-EXEC or mid-DONE, abort the command with no result delivered, and accept a new command on the first edge after RESET deasserts.

Structure
REQ-026 SHALL place the op encodings (OP_HOLD, OP_INV, OP_SHR, OP_SHL), the state encodings and COUNT_W = 3 in a shared package.
REQ-027 SHALL instantiate one sub-module, mode_datapath (4-bit register with async reset, load port and the 4:1 mode mux implementing f), with all sequencing in the parent.

Verification
REQ-028 SHALL cover: data 1011, op invert, count 1 -> res_valid 2 cycles after accept, res_data 0100.
REQ-029 SHALL cover: data 1011, shift right, count 2 -> res_data 0010 after 3 cycles; shift left, count 3 -> 1000 after 4 cycles.
REQ-030 SHALL cover: data 0110, hold, count 0 -> res_valid on the next cycle with 0110; hold, count 7 -> latency 8 with 0110.
REQ-031 SHALL cover: res_ready low for 5 cycles -> res_valid and res_data stable, cmd_ready low, new cmd_valid ignored, with acceptance on the cycle after consume.
REQ-032 SHALL cover: RESET pulse during EXEC of shift left, count 5 -> outputs at reset values, no res_valid, and the next command 1111 invert count 2 returning 1111.
REQ-033 SHALL cover: back-to-back commands with cmd_valid held high and res_ready tied high -> one accept every count+2 cycles with correct results in order.
